// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one UART transmitter
// between N_REQ requesters.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req         - per-requester transmit request, held until ack
//   req_data    - requester i's byte at [i*DW +: DW]
//   ack         - one-cycle completion pulse to the served requester
//   tx_start    - one-cycle start pulse to the transmitter
//   tx_data     - byte latched at grant, stable for the whole frame
//   tx_busy     - transmitter busy flag
//   active_id   - index of the requester being served
//   sched_busy  - high whenever the scheduler is not idle
//   err         - one-cycle pulse when tx_busy never rises after a start
module uart_tx_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned BUSY_TO = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DW-1:0]        req_data,
  output logic [N_REQ-1:0]           ack,
  output logic                       tx_start,
  output logic [DW-1:0]              tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   active_id,
  output logic                       sched_busy,
  output logic                       err
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  id_q, id_d;
  logic [DW-1:0]  data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [IW-1:0]  win_id;
  logic           win_vld;
  logic [IW-1:0]  cand;
  logic           timeout;

  // Round-robin search starting just after the last served index.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IW'((32'(ptr_q) + off) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Timeout fires on the edge where the counter would reach BUSY_TO.
  assign timeout = (state_q == WAIT_HI) && !tx_busy && (cnt_q == CW'(BUSY_TO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      id_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!tx_busy && win_vld) state_d = START;
      START:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy)      state_d = WAIT_LO;
        else if (timeout) state_d = IDLE;
      end
      WAIT_LO: if (!tx_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d   = id_q;
    data_d = data_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (state_q == IDLE && !tx_busy && win_vld) begin
      id_d   = win_id;
      data_d = req_data[32'(win_id)*DW +: DW];
    end
    if (state_q == START) cnt_d = '0;
    if (state_q == WAIT_HI && !tx_busy && cnt_q != CW'(BUSY_TO)) cnt_d = cnt_q + 1'b1;
    if (timeout) begin
      err_d = 1'b1;
      ptr_d = id_q;
    end
    if (state_q == DONE) ptr_d = id_q;
  end

  always_comb begin
    ack = '0;
    if (state_q == DONE) ack[id_q] = 1'b1;
    tx_start   = (state_q == START);
    sched_busy = (state_q != IDLE);
    tx_data    = data_q;
    active_id  = id_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against a
// transaction-level round-robin model with a scripted transmitter.
module tb_uart_tx_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;

  logic            clk, rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [1:0]      active_id;
  logic            sched_busy, err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned mptr;

  uart_tx_sched #(.N_REQ(N), .DW(DW), .BUSY_TO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .active_id(active_id), .sched_busy(sched_busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned rr_pick(input int unsigned p, input logic [N-1:0] r);
    for (int unsigned off = 1; off <= N; off++)
      if (r[(p + off) % N]) return (p + off) % N;
    return N;
  endfunction

  task automatic scramble();
    for (int unsigned i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_start"}, 32'(tx_start), 0);
    chk({tag, "_data"}, 32'(tx_data), 0);
    chk({tag, "_id"}, 32'(active_id), 0);
    chk({tag, "_busy"}, 32'(sched_busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // One complete frame: busy rises d cycles late, stays high len cycles.
  task automatic serve(input int unsigned d, input int unsigned len, input bit drop_mid,
                       input bit drop_on_ack, output int unsigned w);
    logic [DW-1:0] exp_data;
    logic [N-1:0]  oh;
    w = rr_pick(mptr, req);
    exp_data = req_data[w*DW +: DW];
    oh = '0;
    oh[w] = 1'b1;
    tick();
    chk("start_pulse", 32'(tx_start), 1);
    chk("grant_id", 32'(active_id), w);
    chk("grant_data", 32'(tx_data), 32'(exp_data));
    chk("start_busy", 32'(sched_busy), 1);
    tick();
    chk("start_len", 32'(tx_start), 0);
    for (int unsigned i = 0; i < d; i++) begin
      scramble();
      tick();
      chk("wait_hi_ack", 32'(ack), 0);
      chk("wait_hi_data", 32'(tx_data), 32'(exp_data));
    end
    tx_busy = 1'b1;
    for (int unsigned i = 0; i < len; i++) begin
      scramble();
      if (drop_mid && i == 0) req[w] = 1'b0;
      tick();
      chk("wait_lo_ack", 32'(ack), 0);
      chk("wait_lo_data", 32'(tx_data), 32'(exp_data));
      chk("wait_lo_id", 32'(active_id), w);
    end
    tx_busy = 1'b0;
    tick();
    chk("done_ack", 32'(ack), 32'(oh));
    chk("done_data", 32'(tx_data), 32'(exp_data));
    chk("done_err", 32'(err), 0);
    if (drop_on_ack) req[w] = 1'b0;
    tick();
    chk("post_ack", 32'(ack), 0);
    chk("post_idle", 32'(sched_busy), 0);
    mptr = w;
  endtask

  // Frame whose transmitter never responds.
  task automatic timeout_frame(output int unsigned w);
    w = rr_pick(mptr, req);
    tick();
    chk("to_start", 32'(tx_start), 1);
    chk("to_id", 32'(active_id), w);
    tick();
    for (int unsigned i = 1; i < TO; i++) begin
      tick();
      chk("to_err_early", 32'(err), 0);
      chk("to_busy", 32'(sched_busy), 1);
      chk("to_ack", 32'(ack), 0);
    end
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_idle", 32'(sched_busy), 0);
    chk("to_no_ack", 32'(ack), 0);
    req = '0;
    tick();
    chk("to_err_len", 32'(err), 0);
    chk("to_no_start", 32'(tx_start), 0);
    mptr = w;
  endtask

  initial begin
    int unsigned w, prev;
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    tx_busy = 1'b0;
    mptr = N - 1;

    tick();
    tick();
    chk_idle_outputs("reset");
    req = '1;
    scramble();
    tick();
    chk("reset_hold_start", 32'(tx_start), 0);
    chk("reset_hold_busy", 32'(sched_busy), 0);
    req = '0;
    rst_n = 1'b1;
    tick();
    chk("release_idle", 32'(sched_busy), 0);

    // Fairness: all requesting, each drops on its ack.
    req = '1;
    for (int unsigned i = 0; i < N; i++) begin
      serve($urandom_range(0, 3), $urandom_range(1, 12), 1'b0, 1'b1, w);
      chk("rr_order", w, i);
    end
    chk("rr_all_served", 32'(req), 0);

    // Single request with 0xA5, busy one cycle after start for 11 cycles.
    scramble();
    req_data[2*DW +: DW] = 8'hA5;
    req = 4'b0100;
    serve(0, 11, 1'b0, 1'b1, w);
    chk("single_id", w, 2);

    // Foreign busy holds off the grant.
    tx_busy = 1'b1;
    req = 4'b0001;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("foreign_start", 32'(tx_start), 0);
      chk("foreign_busy", 32'(sched_busy), 0);
    end
    tx_busy = 1'b0;
    serve(1, 4, 1'b0, 1'b1, w);
    chk("foreign_id", w, 0);

    // Timeout, then the next grant moves on.
    req = '1;
    timeout_frame(prev);
    req = '1;
    serve(0, 3, 1'b0, 1'b1, w);
    chk("to_next", w, (prev + 1) % N);
    req = '0;

    // Reset during WAIT_LO.
    req = 4'b0110;
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    chk("mid_frame_busy", 32'(sched_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    mptr = N - 1;
    req = '1;
    serve(2, 5, 1'b0, 1'b1, w);
    chk("after_reset_id", w, 0);
    req = '0;
    tick();

    // Randomized frames, timeouts and mid-frame drops.
    for (int unsigned it = 0; it < 30; it++) begin
      req = N'($urandom);
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      scramble();
      if ($urandom_range(0, 7) == 0) timeout_frame(w);
      else serve($urandom_range(0, 3), $urandom_range(1, 12), 1'($urandom),
                 1'($urandom), w);
      req = '0;
      tick();
      chk("gap_idle", 32'(sched_busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4, sets the number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DW, default 8, sets the data byte width per requester.
REQ-003 Parameter BUSY_TO, default 15, sets the number of cycles to wait for tx_busy after tx_start before declaring a timeout.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port req, input, N_REQ bits: per-requester transmit request; held high until the matching ack.
REQ-008 Port req_data, input, N_REQ*DW bits: requester i's byte at bits [i*DW +: DW].
REQ-009 Port ack, output, N_REQ bits: one-cycle completion pulse to the served requester.
REQ-010 Port tx_start, output, 1 bit: start pulse to the transmitter.
REQ-011 Port tx_data, output, DW bits: byte presented to the transmitter.
REQ-012 Port tx_busy, input, 1 bit: transmitter busy flag.
REQ-013 Port active_id, output, clog2(N_REQ) bits: index of the requester currently being served.
REQ-014 Port sched_busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port err, output, 1 bit: one-cycle pulse on a busy timeout.

Function
REQ-016 The state machine SHALL have the states IDLE, START, WAIT_HI, WAIT_LO and DONE.
REQ-017 IDLE SHALL arbitrate only when tx_busy=0 and at least one req bit is high; otherwise it SHALL remain in IDLE.
REQ-018 Arbitration SHALL be round-robin: the search starts at index (ptr+1) mod N_REQ and wraps, and the first high req bit wins.
REQ-019 On a win, the block SHALL register active_id and tx_data = req_data of the winner at the same edge and move to START.
REQ-020 START SHALL last exactly one cycle with tx_start=1, then move to WAIT_HI; tx_start SHALL be 0 in all other states.
REQ-021 WAIT_HI SHALL move to WAIT_LO when tx_busy=1 is sampled.
REQ-022 WAIT_HI SHALL increment a timeout counter each cycle that tx_busy=0; when the counter reaches BUSY_TO, the block SHALL pulse err for one cycle, issue no ack, and return to IDLE.
REQ-023 WAIT_LO SHALL move to DONE when tx_busy=0 is sampled.
REQ-024 DONE SHALL last exactly one cycle with ack[active_id]=1 (all other ack bits 0), then move to IDLE.
REQ-025 ptr SHALL be updated to active_id on leaving DONE, and also on a timeout exit.
REQ-026 tx_data and active_id SHALL remain stable from START through DONE; changes on req_data during a frame SHALL be ignored.
REQ-027 A req deasserted mid-frame SHALL NOT abort the frame; the frame completes and ack still pulses.
REQ-028 Latency: with req high and tx_busy=0 sampled at edge k in IDLE, tx_start SHALL be high in the cycle after edge k.
REQ-029 Back-to-back operation: requests pending at DONE are arbitrated in the following IDLE cycle, giving a minimum of one IDLE cycle between frames.
REQ-030 The timeout counter SHALL clear on entering WAIT_HI and SHALL saturate rather than wrap.

Reset
REQ-031 While rst_n=0: state=IDLE, ptr=N_REQ-1 (requester 0 has first priority), timeout counter=0, and outputs ack=0, tx_start=0, tx_data=0, active_id=0, sched_busy=0, err=0.
REQ-032 A reset asserted mid-frame SHALL abandon the frame immediately, with no ack or err issued.
REQ-033 After reset release, the first arbitration SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-034 Single request: req=4'b0100 with data 0xA5, and a TX model that raises busy 1 cycle after start for 11 cycles -> tx_start for 1 cycle, tx_data=0xA5, active_id=2, ack=4'b0100 for 1 cycle after busy falls.
REQ-035 Fairness: req=4'b1111 held, each requester dropping its req on ack -> grant order 0,1,2,3, with every ack one-hot.
REQ-036 Timeout: tx_busy held 0 after start -> err pulses exactly BUSY_TO cycles after WAIT_HI entry, no ack, and the next grant goes to the next index.
REQ-037 Foreign busy: tx_busy=1 while in IDLE with req=4'b0001 -> no tx_start until tx_busy=0.
REQ-038 Mid-frame reset: rst_n pulsed low during WAIT_LO -> all outputs 0 and the next grant goes to requester 0.
REQ-039 Data stability: req_data toggled every cycle during a frame -> tx_data stays equal to the value latched at grant.
